// File: rtl/mac_pkg.sv
// Shared widths, accumulator-width helper and controller state type for the
// dot-product accumulator.
package mac_pkg;

  localparam int unsigned DefWidthA = 5;
  localparam int unsigned DefWidthB = 7;
  localparam int unsigned DefCntW   = 8;

  // The full product width is enough to hold any single term without loss.
  function automatic int unsigned acc_w(input int unsigned width_a, input int unsigned width_b);
    return width_a + width_b;
  endfunction

  typedef enum logic {
    StAccum,
    StDone
  } state_e;

endpackage

// File: rtl/dot_accum_if.sv
// Beat-in / result-out handshake bundle for dot_accum.
interface dot_accum_if
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH_A = DefWidthA,
  parameter int unsigned WIDTH_B = DefWidthB,
  parameter int unsigned CNT_W   = DefCntW
);

  localparam int unsigned AccW = acc_w(WIDTH_A, WIDTH_B);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] in_a;
  logic [WIDTH_B-1:0] in_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [AccW-1:0]    out_sum;
  logic [CNT_W-1:0]   out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/mac.sv
// Combinational multiply-add: out = A*B + C, truncated to the accumulator width.
module mac
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH_A = DefWidthA,
  parameter int unsigned WIDTH_B = DefWidthB
) (
  input  logic [WIDTH_A-1:0]                  A,
  input  logic [WIDTH_B-1:0]                  B,
  input  logic [acc_w(WIDTH_A, WIDTH_B)-1:0]  C,
  output logic [acc_w(WIDTH_A, WIDTH_B)-1:0]  out
);

  localparam int unsigned AccW = acc_w(WIDTH_A, WIDTH_B);

  assign out = AccW'(A) * AccW'(B) + C;

endmodule

// File: rtl/dot_accum.sv
// Streams (a, b) beats, accumulates a*b per vector and presents the sum and
// saturating beat count once the last beat of the vector is accepted.
module dot_accum
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH_A = DefWidthA,
  parameter int unsigned WIDTH_B = DefWidthB,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic      clk,
  input  logic      rst_n,
  dot_accum_if.slave bus
);

  localparam int unsigned ACC_W = acc_w(WIDTH_A, WIDTH_B);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic [ACC_W-1:0]   mac_out;
  logic [CNT_W-1:0]   count_inc;

  mac #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_mac (
    .A   (bus.in_a),
    .B   (bus.in_b),
    .C   (acc_q),
    .out (mac_out)
  );

  // Count sticks at all-ones rather than wrapping on very long vectors.
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    unique case (state_q)
      StAccum: begin
        if (bus.in_valid) begin
          acc_d   = mac_out;
          count_d = count_inc;
          if (bus.in_last) begin
            out_sum_d   = mac_out;
            out_count_d = count_inc;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = StAccum;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 Parameter WIDTH_A, default 5, width of multiplicand a.
REQ-002 Parameter WIDTH_B, default 7, width of multiplier b.
REQ-003 Parameter CNT_W, default 8, width of term counter.
REQ-004 Derived constant ACC_W = WIDTH_A+WIDTH_B, accumulator/result width, equal to MAC output width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_a  input  WIDTH_A  unsigned operand a.
REQ-010 in_b  input  WIDTH_B  unsigned operand b.
REQ-011 in_last  input  1  marks final beat of a vector.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_sum  output  ACC_W  sum of a*b over the vector, modulo 2^ACC_W.
REQ-015 out_count  output  CNT_W  number of beats in the vector, saturating.

Function
REQ-016 Two states: ACCUM, DONE; ACCUM after reset.
REQ-017 in_ready SHALL be 1 exactly when state is ACCUM; beat accepted iff in_valid && in_ready.
REQ-018 On accepted beat in ACCUM, acc SHALL load MAC(A=in_a, B=in_b, C=acc) and count SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-019 On accepted beat with in_last=1, out_sum SHALL load the same MAC result, out_count the incremented count, state goes DONE.
REQ-020 out_valid SHALL be 1 exactly when state is DONE; out_sum/out_count stable while out_valid=1.
REQ-021 Latency: out_valid asserts the cycle after the last beat is accepted.
REQ-022 In DONE, when out_ready=1: acc and count clear to 0, state returns to ACCUM next cycle; else hold indefinitely.
REQ-023 Beats presented while in_ready=0 SHALL be ignored with no state change.
REQ-024 Accumulation wraps modulo 2^ACC_W with no overflow indication.
REQ-025 Single-beat vector (in_last on first beat) is legal; result = in_a*in_b, count = 1.
REQ-026 Throughput: one beat per cycle within a vector; minimum one-cycle gap (DONE) between vectors.
REQ-027 in_a/in_b/in_last values are don't-care when not accepted.

Reset
REQ-028 rst_n low SHALL immediately force state ACCUM, acc=0, count=0, out_sum=0, out_count=0, out_valid=0.
REQ-029 Reset mid-vector or while DONE SHALL discard partial/pending results; in_ready=1 after the first clock edge following rst_n release.

Structure
REQ-030 Shared package mac_pkg SHALL hold default WIDTH_A/WIDTH_B, ACC_W function, and state enum typedef.
REQ-031 Multiply-add SHALL be a single instance of existing combinational MAC (ports A, B, C, out) with acc wired to C.
REQ-032 acc, count, out_sum, out_count, state are the only registers.

Verification
REQ-033 Vector (13,23),(15,21,last), out_ready=1 -> out_sum=614, out_count=2, out_valid for one cycle.
REQ-034 Vector (31,127),(31,127,last) -> out_sum=3778 (7874 mod 4096), out_count=2.
REQ-035 Single beat (0,0,last) -> out_sum=0, out_count=1; next vector (1,1,last) -> out_sum=1 (acc cleared).
REQ-036 out_ready low 5 cycles after result -> out_valid and values held, in_ready=0, presented beats ignored.
REQ-037 rst_n pulse after 2 of 3 beats -> outputs 0; fresh vector (2,3,last) -> out_sum=6, out_count=1.
REQ-038 300 beats (1,1), last on 300th, CNT_W=8 -> out_count=255, out_sum=300.
